// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM state
// encoding and small opcode classification helpers.
package alu_pkg;

  // Operation select codes (aluCtr)
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_alu_mdu.sv
// Iterative multiply/divide datapath. Operands are reduced to magnitudes on
// load (the first shift-add / restoring-subtract step is folded into the load
// edge), one step per step_i cycle follows, and hi_o/lo_o present the
// sign-corrected result once the last step has been taken.
module seq_alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q;      // {upper, lower}: product or {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [CNT_W-1:0]   cnt_q;      // steps still to be taken
  logic               div_q;
  logic               raw_q;      // divide by zero: acc holds the final hi/lo as-is
  logic               neg_lo_q;   // negate product / quotient
  logic               neg_hi_q;   // negate remainder

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  // One shift-add multiply step: add multiplicand when the multiplier LSB is set, shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   mcand);
    logic [WIDTH:0] upper;
    upper = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) upper = upper + {1'b0, mcand};
    return {upper, acc[WIDTH-1:1]};
  endfunction

  // One restoring divide step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   dvsr);
    logic [WIDTH:0] shifted, diff;
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    return {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  endfunction

  // Operand magnitudes and sign flags for the load edge.
  // NOTE: every signal driven here gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    sign_a = is_signed_i & a_i[WIDTH-1];
    sign_b = is_signed_i & b_i[WIDTH-1];
    mag_a  = sign_a ? -a_i : a_i;
    mag_b  = sign_b ? -b_i : b_i;
  end

  // Load operands (with the first step) or advance the iteration.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      raw_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (load_i) begin
      div_q    <= is_div_i;
      neg_lo_q <= sign_a ^ sign_b;
      neg_hi_q <= sign_a;
      cnt_q    <= CNT_W'(WIDTH - 1);
      if (is_div_i) begin
        opnd_q <= mag_b;
        raw_q  <= (b_i == '0);
        acc_q  <= (b_i == '0) ? {a_i, {WIDTH{1'b1}}}
                              : div_step({{WIDTH{1'b0}}, mag_a}, mag_b);
      end else begin
        opnd_q <= mag_a;
        raw_q  <= 1'b0;
        acc_q  <= mul_step({{WIDTH{1'b0}}, mag_b}, mag_a);
      end
    end else if (step_i) begin
      acc_q <= div_q ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

  // Sign correction of the finished magnitudes.
  always_comb begin
    prod = neg_lo_q ? -acc_q : acc_q;
    quo  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (raw_q) begin
      {hi_o, lo_o} = acc_q;
    end else if (div_q) begin
      hi_o = rem;
      lo_o = quo;
    end else begin
      {hi_o, lo_o} = prod;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered EX-stage ALU: single-cycle logic/arithmetic ops plus an iterative
// multiply/divide unit with HI/LO registers and a start/busy/done handshake.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       aluCtr,
  output logic [WIDTH-1:0] aluRes,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q, hi_q, lo_q;
  logic             zero_q, ovf_q, done_q;

  logic [WIDTH-1:0] sc_res, sum, diff;
  logic             sc_ovf;
  logic             accept_single, mdu_load, mdu_last;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;

  assign accept_single = (state_q == ST_IDLE) && start && !is_muldiv(aluCtr);
  assign mdu_load      = (state_q == ST_IDLE) && start &&  is_muldiv(aluCtr);

  seq_alu_mdu #(.WIDTH(WIDTH)) u_mdu (
    .clk        (clk),
    .reset      (reset),
    .load_i     (mdu_load),
    .step_i     ((state_q == ST_MUL) || (state_q == ST_DIV)),
    .is_div_i   (is_div_op(aluCtr)),
    .is_signed_i(is_signed_op(aluCtr)),
    .a_i        (input1),
    .b_i        (input2),
    .last_o     (mdu_last),
    .hi_o       (mdu_hi),
    .lo_o       (mdu_lo)
  );

  // Single-cycle result and signed overflow of ADD/SUB.
  always_comb begin
    sum    = input1 + input2;
    diff   = input1 - input2;
    sc_res = '0;
    sc_ovf = 1'b0;
    case (aluCtr)
      OP_AND:  sc_res = input1 & input2;
      OP_OR:   sc_res = input1 | input2;
      OP_XOR:  sc_res = input1 ^ input2;
      OP_NOR:  sc_res = ~(input1 | input2);
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      OP_MFHI: sc_res = hi_q;
      OP_MFLO: sc_res = lo_q;
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: sc_res = '0;
      default: sc_res = '0;
    endcase
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mdu_load) begin
        if (!is_div_op(aluCtr))   state_d = ST_MUL;
        else if (input2 == '0)    state_d = ST_FIN;
        else                      state_d = ST_DIV;
      end
      ST_MUL, ST_DIV: if (mdu_last) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result, HI/LO and done-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept_single) begin
        res_q  <= sc_res;
        zero_q <= (sc_res == '0);
        ovf_q  <= sc_ovf;
        done_q <= 1'b1;
      end else if (state_q == ST_FIN) begin
        hi_q   <= mdu_hi;
        lo_q   <= mdu_lo;
        res_q  <= mdu_lo;
        zero_q <= (mdu_lo == '0);
        ovf_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign aluRes   = res_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed corner cases followed
// by random operations, all compared against an arithmetic reference model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] input1, input2;
  logic [3:0]   aluCtr;
  logic [W-1:0] aluRes, hi, lo;
  logic         zero, overflow, busy, done;

  int           n_vec  = 0;
  int           n_fail = 0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  lat;
  } exp_t;

  seq_alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .input1  (input1),
    .input2  (input2),
    .aluCtr  (aluCtr),
    .aluRes  (aluRes),
    .zero    (zero),
    .overflow(overflow),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain 64-bit arithmetic on the operation's definition.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    exp_t        e;
    longint      sa, sb, s, q, r;
    logic [63:0] ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.res = '0; e.ovf = 1'b0; e.hi = cur_hi; e.lo = cur_lo; e.lat = 8'd1;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0011: e.res = a ^ b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin
        s = sa + sb; e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sa - sb; e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0100: e.res = (ua < ub) ? 32'd1 : 32'd0;
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1101: e.res = cur_hi;
      4'b1110: e.res = cur_lo;
      4'b1000: begin
        s = sa * sb; e.hi = s[63:32]; e.lo = s[31:0]; e.lat = 8'd33;
      end
      4'b1001: begin
        up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; e.lat = 8'd33;
      end
      4'b1010: begin
        if (b == 0) begin e.hi = a; e.lo = '1; e.lat = 8'd2; end
        else begin q = sa / sb; r = sa % sb; e.hi = r[31:0]; e.lo = q[31:0]; e.lat = 8'd33; end
      end
      4'b1011: begin
        if (b == 0) begin e.hi = a; e.lo = '1; e.lat = 8'd2; end
        else begin up = ua / ub; e.lo = up[31:0]; up = ua % ub; e.hi = up[31:0]; e.lat = 8'd33; end
      end
      default: e.res = '0;
    endcase
    if (op[3:2] == 2'b10) e.res = e.lo;
    return e;
  endfunction

  // Issue one operation, wait (bounded) for done, compare everything, confirm done is a pulse.
  // poke1/poke2: cycle numbers at which an ADD start is pulsed while the op is in flight.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke1 = 0, input int poke2 = 0);
    exp_t  e;
    int    n;
    logic  busy_ok;
    string t;
    e = model(op, a, b, m_hi, m_lo);
    t = $sformatf("op%h(%h,%h)", op, a, b);
    start = 1'b1; aluCtr = op; input1 = a; input2 = b;
    n = 0; busy_ok = 1'b1;
    do begin
      tick();
      n++;
      start = 1'b0;
      if (!done && !busy) busy_ok = 1'b0;
      if (!done && (n == poke1 || n == poke2)) begin
        start = 1'b1; aluCtr = OP_ADD; input1 = $urandom; input2 = $urandom;
      end
    end while (!done && n < 100);
    start = 1'b0;
    check({t, " latency"},  64'(n),        64'(e.lat));
    check({t, " busy"},     64'(busy_ok),  64'(1));
    check({t, " idle"},     64'(busy),     64'(0));
    check({t, " aluRes"},   64'(aluRes),   64'(e.res));
    check({t, " zero"},     64'(zero),     64'(e.res == 0));
    check({t, " overflow"}, 64'(overflow), 64'(e.ovf));
    check({t, " hi"},       64'(hi),       64'(e.hi));
    check({t, " lo"},       64'(lo),       64'(e.lo));
    m_hi = e.hi;
    m_lo = e.lo;
    tick();
    check({t, " done pulse"}, 64'(done), 64'(0));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic       seen;
    logic [3:0] rop;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; aluCtr = '0; input1 = '0; input2 = '0;
    tick(); tick();
    check("reset aluRes",   64'(aluRes),   64'(0));
    check("reset zero",     64'(zero),     64'(1));
    check("reset overflow", 64'(overflow), 64'(0));
    check("reset busy",     64'(busy),     64'(0));
    check("reset done",     64'(done),     64'(0));
    check("reset hi",       64'(hi),       64'(0));
    check("reset lo",       64'(lo),       64'(0));
    reset = 1'b0;
    tick();

    // Directed corner cases
    run_op(OP_ADD,   32'h7FFF_FFFF, 32'h0000_0001);
    run_op(OP_SUB,   32'd5,         32'd5);
    run_op(OP_SUB,   32'h8000_0000, 32'd1);
    run_op(OP_SLT,   32'hFFFF_FFFF, 32'd1);
    run_op(OP_SLTU,  32'hFFFF_FFFF, 32'd1);
    run_op(OP_NOR,   32'h0F0F_0000, 32'h0000_00F0);
    run_op(4'b0101,  32'h1234_5678, 32'h1);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7);
    run_op(OP_MFHI,  32'h0,         32'h0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIVU,  32'd7,         32'd0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIVU,  32'hFFFF_FFFF, 32'd10);

    // ADD starts pulsed mid-MUL and during the final cycle are ignored
    run_op(OP_MULT,  32'd12345,     32'hFFFF_FF00, 3, 32);
    run_op(OP_MFLO,  32'h0,         32'h0);

    // Reset in the middle of a divide aborts it without a done pulse
    start = 1'b1; aluCtr = OP_DIV; input1 = 32'd1000; input2 = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mid-div busy", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy",   64'(busy),   64'(0));
    check("abort hi",     64'(hi),     64'(0));
    check("abort lo",     64'(lo),     64'(0));
    check("abort aluRes", 64'(aluRes), 64'(0));
    check("abort zero",   64'(zero),   64'(1));
    check("abort done",   64'(done),   64'(0));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("abort no done", 64'(seen), 64'(0));
    m_hi = '0;
    m_lo = '0;
    run_op(OP_MFHI, 32'h0, 32'h0);

    // Random operations
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = pick();
      rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
      run_op(rop, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
